// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divider and
// the half-bit derivation used to find the middle of the start bit.
package uart_pkg;

  // 10 MHz clock / 115200 baud, rounded.
  localparam int CLK_CY_PER_BIT_DEFAULT = 87;

  // Frame states, common to the transmitter and the receiver.
  typedef enum logic [2:0] {
    STATE_IDLE    = 3'd0,
    STATE_START   = 3'd1,
    STATE_DATA    = 3'd2,
    STATE_STOP    = 3'd3,
    STATE_CLEANUP = 3'd4,
    STATE_BREAK   = 3'd5
  } uart_state_e;

  // Cycles from the start edge to the middle of the start bit.
  function automatic int half_bit(input int cy_per_bit);
    return cy_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial pin plus one history
// flop for falling-edge detection. Everything resets to the idle level (1).
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_synced,
  output logic o_fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  // Next values: shift the pin through the chain.
  always_comb begin
    sync1_d = i_rx;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // Synchroniser and history registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign o_synced = sync2_q;
  assign o_fall   = hist_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Finds the middle of each bit by counting clock cycles
// from the start edge, shifts data in LSB first and strobes each good byte.
// A low stop bit reports a framing error and waits for the line to return
// high so a held-low line (break) cannot generate repeated frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_CY_PER_BIT = CLK_CY_PER_BIT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_Dv,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int         HALF    = half_bit(CLK_CY_PER_BIT);
  localparam logic [7:0] HALF_M1 = 8'(HALF - 1);
  localparam logic [7:0] BIT_M1  = 8'(CLK_CY_PER_BIT - 1);

  logic rx_synced;
  logic rx_fall;

  uart_rx_sync u_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_rx     (i_Rx_Serial),
    .o_synced (rx_synced),
    .o_fall   (rx_fall)
  );

  uart_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        ferr_q, ferr_d;
  logic        active_q, active_d;

  // Frame FSM next-state logic: counter clears on every state change and at
  // every sample point, strobes default low.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 8'd1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;

    case (state_q)
      STATE_IDLE: begin
        cnt_d = 8'd0;
        idx_d = 3'd0;
        if (rx_fall) begin
          state_d = STATE_START;
        end
      end

      STATE_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = 8'd0;
          if (!rx_synced) begin
            active_d = 1'b1;
            state_d  = STATE_DATA;
          end else begin
            // Line already back high: a glitch, not a start bit.
            state_d = STATE_IDLE;
          end
        end
      end

      STATE_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d          = 8'd0;
          shift_d[idx_q] = rx_synced;
          if (idx_q == 3'd7) begin
            // The 3-bit index wraps here; it can never reach 8.
            idx_d   = 3'd0;
            state_d = STATE_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      STATE_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = 8'd0;
          if (rx_synced) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = STATE_CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = STATE_BREAK;
          end
        end
      end

      STATE_CLEANUP: begin
        cnt_d    = 8'd0;
        active_d = 1'b0;
        state_d  = STATE_IDLE;
      end

      STATE_BREAK: begin
        cnt_d    = 8'd0;
        active_d = 1'b0;
        if (rx_synced) begin
          state_d = STATE_IDLE;
        end
      end

      default: begin
        cnt_d   = 8'd0;
        idx_d   = 3'd0;
        state_d = STATE_IDLE;
      end
    endcase
  end

  // Frame FSM state, datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= STATE_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      byte_q   <= 8'd0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  assign o_Rx_Dv        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two receivers (default divider and the minimum divider
// of 4) fed by a behavioural 8N1 transmitter. Each issued frame pushes its
// expected outcome (error flag, byte, strobe cycle) into a queue; a monitor
// pops and compares whenever a receiver strobes.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB0 = 87;
  localparam int CPB1 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1;
  logic       dv0, ferr0, act0;
  logic       dv1, ferr1, act1;
  logic [7:0] byte0, byte1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // {frame_err, byte, strobe cycle}
  logic [40:0] exp_q0[$];
  logic [40:0] exp_q1[$];
  logic [7:0]  last_good [2];
  int          exp_rises [2];
  int          rises [2];
  logic        act_prev [2];
  logic [7:0]  cnt1_max = 8'd0;

  uart_rx #(.CLK_CY_PER_BIT(CPB0)) dut0 (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_Rx_Serial    (rx0),
    .o_Rx_Dv        (dv0),
    .o_Rx_Byte      (byte0),
    .o_Rx_Frame_Err (ferr0),
    .o_Rx_Active    (act0)
  );

  uart_rx #(.CLK_CY_PER_BIT(CPB1)) dut1 (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_Rx_Serial    (rx1),
    .o_Rx_Dv        (dv1),
    .o_Rx_Byte      (byte1),
    .o_Rx_Frame_Err (ferr1),
    .o_Rx_Active    (act1)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Hold a receiver's line at v for n clock cycles; always returns 1 time
  // unit after a rising edge.
  task automatic drive(input int inst, input logic v, input int n);
    if (inst == 0) rx0 = v;
    else           rx1 = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural transmitter plus reference model. The start edge driven at
  // cycle n is seen by IDLE two cycles later (synchroniser); the strobe
  // follows HALF + 9 bit periods + 1 cycles after that.
  task automatic send_frame(input int inst, input logic [7:0] b, input logic stop, input int gap);
    int         cpb;
    int         t_strobe;
    logic [7:0] eb;
    cpb      = (inst == 0) ? CPB0 : CPB1;
    t_strobe = cyc + 2 + cpb / 2 + 9 * cpb + 1;
    if (stop) begin
      eb              = b;
      last_good[inst] = b;
    end else begin
      eb = last_good[inst];
    end
    if (inst == 0) exp_q0.push_back({~stop, eb, 32'(t_strobe)});
    else           exp_q1.push_back({~stop, eb, 32'(t_strobe)});
    exp_rises[inst]++;
    drive(inst, 1'b0, cpb);
    for (int k = 0; k < 8; k++) drive(inst, b[k], cpb);
    drive(inst, stop, cpb);
    drive(inst, 1'b1, gap);
  endtask

  task automatic check_evt(input int inst, input logic dv, input logic fe, input logic [7:0] b);
    logic [40:0] e;
    if ((inst == 0 && exp_q0.size() == 0) || (inst == 1 && exp_q1.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL unexpected_strobe inst=%0d dv=%0b ferr=%0b byte=%02h cyc=%0d required=none",
               inst, dv, fe, b, cyc);
      return;
    end
    e = (inst == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    chk($sformatf("strobe_kind%0d {dv,ferr}", inst), 32'({dv, fe}), e[40] ? 32'd1 : 32'd2);
    chk($sformatf("rx_byte%0d", inst), 32'(b), 32'(e[39:32]));
    chk($sformatf("strobe_cycle%0d", inst), 32'(cyc), e[31:0]);
  endtask

  // Monitor: sample between edges, check strobes, count Active rises.
  always @(negedge clk) begin
    if (dv0 || ferr0) check_evt(0, dv0, ferr0, byte0);
    if (dv1 || ferr1) check_evt(1, dv1, ferr1, byte1);
    if (act0 && !act_prev[0]) rises[0]++;
    if (act1 && !act_prev[1]) rises[1]++;
    act_prev[0] = act0;
    act_prev[1] = act1;
    if (dut1.cnt_q > cnt1_max) cnt1_max = dut1.cnt_q;
  end

  initial begin
    logic [7:0] rb;
    int         glen;
    int         rise_snap;
    last_good[0] = 8'd0;
    last_good[1] = 8'd0;
    exp_rises[0] = 0;
    exp_rises[1] = 0;
    rises[0]     = 0;
    rises[1]     = 0;
    act_prev[0]  = 1'b0;
    act_prev[1]  = 1'b0;

    // Reset values
    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dv0", 32'(dv0), 0);
    chk("reset_byte0", 32'(byte0), 0);
    chk("reset_ferr0", 32'(ferr0), 0);
    chk("reset_act0", 32'(act0), 0);
    chk("reset_dv1", 32'(dv1), 0);
    chk("reset_byte1", 32'(byte1), 0);
    chk("reset_state0", 32'(dut0.state_q), 32'(STATE_IDLE));
    rst = 1'b0;
    drive(0, 1'b1, 5);

    // Loopback pair, back-to-back, then the all-zero / all-one patterns
    send_frame(0, 8'hA5, 1'b1, 0);
    send_frame(0, 8'h3C, 1'b1, CPB0);
    send_frame(0, 8'h00, 1'b1, CPB0);
    send_frame(0, 8'hFF, 1'b1, CPB0);

    // Glitches shorter than half a bit: no activity, back in IDLE
    rise_snap = rises[0];
    drive(0, 1'b0, 20);
    drive(0, 1'b1, CPB0);
    chk("glitch20_state", 32'(dut0.state_q), 32'(STATE_IDLE));
    glen = $urandom_range(1, CPB0 / 2 - 1);
    drive(0, 1'b0, glen);
    drive(0, 1'b1, CPB0);
    chk("glitch_rand_state", 32'(dut0.state_q), 32'(STATE_IDLE));
    chk("glitch_no_active", 32'(rises[0]), 32'(rise_snap));

    // Random frames with random gaps
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      send_frame(0, rb, 1'b1, $urandom_range(0, CPB0));
    end

    // Framing error followed by a long break, then a good frame
    send_frame(0, 8'h55, 1'b0, 0);
    drive(0, 1'b0, 2000);
    drive(0, 1'b1, CPB0);
    chk("break_byte_held", 32'(byte0), 32'(last_good[0]));
    chk("break_state_idle", 32'(dut0.state_q), 32'(STATE_IDLE));
    send_frame(0, 8'h81, 1'b1, CPB0);

    // Reset in the middle of data bit 4, then a clean frame
    rb = 8'($urandom);
    drive(0, 1'b0, CPB0);
    for (int k = 0; k < 4; k++) drive(0, rb[k], CPB0);
    drive(0, rb[4], CPB0 / 2);
    exp_rises[0]++;
    rst = 1'b1;
    rx0 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_good[0] = 8'd0;
    last_good[1] = 8'd0;
    chk("midrst_dv", 32'(dv0), 0);
    chk("midrst_ferr", 32'(ferr0), 0);
    chk("midrst_act", 32'(act0), 0);
    chk("midrst_byte", 32'(byte0), 0);
    chk("midrst_state", 32'(dut0.state_q), 32'(STATE_IDLE));
    drive(0, 1'b1, CPB0);
    send_frame(0, 8'h7E, 1'b1, CPB0);

    // Minimum divider
    send_frame(1, 8'h96, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      send_frame(1, rb, 1'b1, $urandom_range(0, CPB1));
    end
    drive(1, 1'b1, 4 * CPB1);
    drive(0, 1'b1, 2 * CPB0);

    // Final accounting
    chk("queue0_drained", 32'(exp_q0.size()), 0);
    chk("queue1_drained", 32'(exp_q1.size()), 0);
    chk("active_rises0", 32'(rises[0]), 32'(exp_rises[0]));
    chk("active_rises1", 32'(rises[1]), 32'(exp_rises[1]));
    chk("small_cnt_max_le_3", 32'(cnt1_max <= 8'd3), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receiver for the 8N1 serial frame that `uart_tx` produces: one start bit (low), 8 data bits LSB first, one stop bit (high), with no parity. It synchronises the asynchronous serial line, finds the middle of each bit by counting clock cycles, and presents each received byte with a one-cycle valid strobe. It sits at the pin side of the design, opposite `uart_tx`, and shares the same clock and baud parameter (10 MHz, 115200 baud, 87 cycles per bit).

## Interface
- `CLK_CY_PER_BIT`, default 87: input clock cycles per bit. Legal range 4..255.
- `i_clk`  input  1  system clock, rising edge.
- `i_rst`  input  1  reset, synchronous, active-high.
- `i_Rx_Serial`  input  1  asynchronous serial line; idles high.
- `o_Rx_Dv`  output  1  one-cycle pulse; `o_Rx_Byte` is valid in that cycle.
- `o_Rx_Byte`  output  8  last good byte; holds its value until the next good frame.
- `o_Rx_Frame_Err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `o_Rx_Active`  output  1  high from start-bit confirmation until the frame completes.

## Operation
- **Synchroniser.** Two flops plus one edge-history flop on `i_Rx_Serial`, all reset to 1. A falling edge is history=1 and synced=0.
- **Constants.** HALF = CLK_CY_PER_BIT/2 (integer, 43 at the default). The counter is 8 bits. It clears on every state change and at each sample point.
- **STATE_IDLE.** Counter and bit index are 0. Move to STATE_START on a synced falling edge.
- **STATE_START.** Count to HALF-1, then sample the synced line.
  - Low: set `o_Rx_Active`, go to STATE_DATA.
  - High: treat as a glitch and return to STATE_IDLE with no output activity.
- **STATE_DATA.** Count to CLK_CY_PER_BIT-1, then sample the line into shift bit [idx], LSB first.
  - idx 0..6: increment idx and stay.
  - idx 7: go to STATE_STOP with idx = 0. Do not compare the 3-bit idx against 8.
- **STATE_STOP.** Count to CLK_CY_PER_BIT-1, then sample the line.
  - High: load `o_Rx_Byte` from the shift register, pulse `o_Rx_Dv`, go to STATE_CLEANUP.
  - Low: pulse `o_Rx_Frame_Err`, leave `o_Rx_Byte` unchanged, go to STATE_BREAK.
- **STATE_CLEANUP.** Lasts one cycle. Clear `o_Rx_Active`, go to STATE_IDLE.
- **STATE_BREAK.** Clear `o_Rx_Active`. Stay until the synced line is high, then go to STATE_IDLE. This prevents a held-low line (break) from producing repeated frames.
- **Default.** Any undefined state goes to STATE_IDLE.

## Timing
- **Reset values.** All outputs 0. State STATE_IDLE. Shift register 0. Synchroniser flops 1.
- **Synchroniser delay.** The synced line lags the pin by 2 cycles.
- **Cycle schedule.** Let T be the cycle in which IDLE sees the falling edge.
  - Start sample at T+HALF.
  - Data bit k sampled at T+HALF+87·(k+1).
  - Stop sample at T+HALF+9·87 = T+826 at the default.
  - `o_Rx_Dv` / `o_Rx_Frame_Err` high during cycle T+827 only.
  - `o_Rx_Active` is high from T+HALF+1 through T+827 (good frame) or through T+827 (framing error; cleared on entry to STATE_BREAK).
- **Back-to-back frames.** A new start edge is accepted in IDLE. Minimum frame spacing is 10·CLK_CY_PER_BIT cycles, matching `uart_tx`, which uses one idle bit plus cleanup.
- **No back-pressure.** `o_Rx_Dv` is a strobe; the consumer must capture it in the same cycle.
- **Reset mid-frame.** The receiver returns to IDLE within one cycle and all outputs go to 0. If the line is low when reset releases, the synchroniser reset value of 1 makes this look like a falling edge. That may cause a framing error on the remaining bits of the interrupted frame; this behaviour is accepted.
- **Glitch rejection.** Any low pulse shorter than HALF cycles on the synced line is rejected at the start sample.

## Structure
- Shared package `uart_pkg`:
  - state localparams (IDLE, START, DATA, STOP, CLEANUP, BREAK; 3 bits), shared with `uart_tx`;
  - `CLK_CY_PER_BIT` default;
  - HALF derivation.
- Sub-module `uart_rx_sync`: 2-flop synchroniser plus edge-history flop. Outputs synced level and falling-edge pulse; synchronous reset to 1.
- Top `uart_rx`: FSM, counter, bit index, shift register, output registers.

## Test plan
- **Loopback.** `uart_tx` → `uart_rx`, send 0xA5 then 0x3C back-to-back. Expect two `o_Rx_Dv` pulses with `o_Rx_Byte` = 0xA5 then 0x3C, and no `o_Rx_Frame_Err`.
- **Edge patterns.** Drive 0x00 and 0xFF frames directly. Byte matches; `o_Rx_Dv` pulse lands exactly at T+827 for each.
- **Glitch.** Low pulse of 20 cycles on an idle line. No `o_Rx_Active`, no `o_Rx_Dv`, state returns to IDLE.
- **Framing error.** Send 0x55 with the stop bit low, then hold the line low for 2000 cycles, then release. Expect exactly one `o_Rx_Frame_Err` pulse and `o_Rx_Byte` unchanged. After the line goes high, a following 0x81 frame is received correctly.
- **Reset mid-frame.** Assert `i_rst` for 1 cycle during data bit 4. All outputs read 0 the next cycle; a clean 0x7E frame afterwards is received correctly.
- **Small parameter.** `CLK_CY_PER_BIT` = 4: loopback of 0x96 succeeds, and the counter never exceeds 3.
